// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_pkg
// Purpose  : Shared types and constants for the instruction prefetch unit.
//            Holds the default datapath widths, the cache request-type codes
//            and the fetch-queue entry type {pc, ins}.
// Revision : 1.0  initial release
// ============================================================================
package ifu_pkg;

  localparam int IFU_CPU_WIDTH = 32;
  localparam int IFU_INS_WIDTH = 32;
  localparam int IFU_ADR_WIDTH = 32;

  // Bytes per instruction; the sequential PC advances by this amount.
  localparam int INS_BYTES = IFU_INS_WIDTH / 8;

  localparam logic [1:0] REQ_READ  = 2'b00;
  localparam logic [1:0] REQ_WRITE = 2'b01;

  typedef struct packed {
    logic [IFU_CPU_WIDTH-1:0] pc;
    logic [IFU_INS_WIDTH-1:0] ins;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/uni_if.sv
`default_nettype none
// ============================================================================
// Module   : uni_if
// Purpose  : Generic valid/ready memory port used between cores and caches.
// Ports    : valid/addr/size/reqtyp/wdata driven by the master,
//            ready/rdata driven by the slave. rdata is valid in the
//            valid & ready cycle.
// Revision : 1.0  initial release
// ============================================================================
interface uni_if #(
  parameter int ADR_WIDTH = 32,
  parameter int DAT_WIDTH = 32
);
  logic                 valid;
  logic                 ready;
  logic [ADR_WIDTH-1:0] addr;
  logic [1:0]           size;
  logic [1:0]           reqtyp;
  logic [DAT_WIDTH-1:0] wdata;
  logic [DAT_WIDTH-1:0] rdata;

  modport Master (output valid, addr, size, reqtyp, wdata, input ready, rdata);
  modport Slave  (input valid, addr, size, reqtyp, wdata, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/ifq_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifq_fifo
// Purpose  : Fetch queue. Power-of-two deep FIFO with a synchronous clear
//            and an occupancy count. The head entry is shown combinationally.
// Ports    : clk, rst   clock / synchronous reset (also zeroes all entries)
//            clr        synchronous clear of pointers and count
//            push, din  write an entry (caller guarantees not full)
//            pop        drop the head entry (caller guarantees not empty)
//            head       current head entry
//            count      number of stored entries, 0..DEPTH
// Revision : 1.0  initial release
// ============================================================================
module ifq_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic [63:0]
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  entry_t                 din,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/stl_reg.sv
`default_nettype none
// ============================================================================
// Module   : stl_reg
// Purpose  : Plain enabled register with synchronous active-high reset.
// Ports    : clk, rst   clock / synchronous reset
//            wen        load enable
//            din, dout  data in / registered data out
// Revision : 1.0  initial release
// ============================================================================
module stl_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= RESET_VAL;
    end else if (wen) begin
      dout <= din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : ifu_prefetch
// Purpose  : Instruction fetch unit with a sequential fetch PC and an
//            FQ_DEPTH-entry fetch queue between the I-cache and decode.
//            A redirect (i_flush) drops everything queued or in flight and
//            restarts fetch at the aligned i_flush_pc.
// Ports    : i_clk, i_rst          clock / synchronous active-high reset
//            iCacheIf_M            I-cache master port
//            i_flush, i_flush_pc   redirect and its target
//            i_fetch_hold          suppress new (not pending) requests
//            o_post_valid          instruction available to decode
//            i_post_ready          decode accepts
//            o_ifu_pc, o_ifu_ins   head instruction and its PC
//            o_fq_count            queue occupancy
// Revision : 1.0  initial release
// ============================================================================
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int                   CPU_WIDTH = IFU_CPU_WIDTH,
  parameter int                   INS_WIDTH = IFU_INS_WIDTH,
  parameter int                   ADR_WIDTH = IFU_ADR_WIDTH,
  parameter int                   FQ_DEPTH  = 4,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h8000_0000,
  parameter bit                   BYPASS    = 1'b1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  uni_if.Master                       iCacheIf_M,
  input  logic                        i_flush,
  input  logic [CPU_WIDTH-1:0]        i_flush_pc,
  input  logic                        i_fetch_hold,
  output logic                        o_post_valid,
  input  logic                        i_post_ready,
  output logic [CPU_WIDTH-1:0]        o_ifu_pc,
  output logic [INS_WIDTH-1:0]        o_ifu_ins,
  output logic [$clog2(FQ_DEPTH):0]   o_fq_count
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;

  logic [CPU_WIDTH-1:0] fetch_pc;
  logic [CPU_WIDTH-1:0] fetch_pc_nxt;
  logic                 fetch_pc_wen;
  logic                 req_pend;
  logic                 req_pend_nxt;
  logic [CW-1:0]        count;
  logic                 req_valid;
  logic                 csh;
  logic                 bypass;
  logic                 push;
  logic                 pop;
  fetch_entry_t         head;
  fetch_entry_t         new_entry;

  // Request: a pending request is held until accepted regardless of hold or
  // queue level; only a redirect withdraws it. Fullness uses the registered
  // count so decode's ready never reaches the cache valid combinationally.
  assign req_valid = !i_flush &&
                     (req_pend || (!i_fetch_hold && (count < CW'(FQ_DEPTH))));
  assign csh       = req_valid && iCacheIf_M.ready;

  assign iCacheIf_M.valid  = req_valid;
  assign iCacheIf_M.addr   = fetch_pc[ADR_WIDTH-1:0];
  assign iCacheIf_M.size   = 2'b10;
  assign iCacheIf_M.reqtyp = REQ_READ;
  assign iCacheIf_M.wdata  = '0;

  assign new_entry = '{pc: fetch_pc, ins: iCacheIf_M.rdata[INS_WIDTH-1:0]};

  // Bypass: with an empty queue the response goes straight to decode. csh is
  // already false during a flush, so the bypass cannot leak a discarded word.
  assign bypass = BYPASS && csh && (count == '0);

  assign o_post_valid = !i_flush && ((count != '0) || bypass);
  assign o_ifu_pc     = bypass ? new_entry.pc  : head.pc;
  assign o_ifu_ins    = bypass ? new_entry.ins : head.ins;
  assign o_fq_count   = count;

  // A bypassed word that decode takes this cycle never enters the queue; the
  // queue is empty then, so the FIFO itself must not pop either.
  assign push = csh && !(bypass && i_post_ready);
  assign pop  = o_post_valid && i_post_ready && !bypass;

  // Redirect target is forced onto an instruction boundary.
  assign fetch_pc_wen = i_flush || csh;
  assign fetch_pc_nxt = i_flush ? (i_flush_pc & ~CPU_WIDTH'(INS_BYTES - 1))
                                : (fetch_pc + CPU_WIDTH'(INS_BYTES));

  assign req_pend_nxt = req_valid && !iCacheIf_M.ready;

  stl_reg #(
    .WIDTH     (CPU_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_fetch_pc (
    .clk  (i_clk),
    .rst  (i_rst),
    .wen  (fetch_pc_wen),
    .din  (fetch_pc_nxt),
    .dout (fetch_pc)
  );

  stl_reg #(
    .WIDTH     (1),
    .RESET_VAL (1'b0)
  ) u_req_pend (
    .clk  (i_clk),
    .rst  (i_rst),
    .wen  (1'b1),
    .din  (req_pend_nxt),
    .dout (req_pend)
  );

  ifq_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fq (
    .clk   (i_clk),
    .rst   (i_rst),
    .clr   (i_flush),
    .push  (push),
    .din   (new_entry),
    .pop   (pop),
    .head  (head),
    .count (count)
  );

endmodule
`default_nettype wire

// File: tb/tb_ifu_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_prefetch
// Purpose  : Self-checking bench for ifu_prefetch. Two instances (bypass on
//            and off) share the same stimulus; each has its own transaction
//            model: a queue of undelivered {pc, ins} pairs and a model PC.
// Revision : 1.0  initial release
// ============================================================================
module tb_ifu_prefetch;
  import ifu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] flush_pc;
  logic        hold;
  logic        post_ready;
  logic        cache_ready;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int delivered [2];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam bit BYP = (g == 0);

    uni_if #(.ADR_WIDTH(32), .DAT_WIDTH(32)) cif ();
    logic        pv;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic [2:0]  cnt;

    assign cif.ready = cache_ready;
    assign cif.rdata = rdata;

    ifu_prefetch #(
      .FQ_DEPTH (DEPTH),
      .RESET_PC (32'h8000_0000),
      .BYPASS   (BYP)
    ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .iCacheIf_M   (cif.Master),
      .i_flush      (flush),
      .i_flush_pc   (flush_pc),
      .i_fetch_hold (hold),
      .o_post_valid (pv),
      .i_post_ready (post_ready),
      .o_ifu_pc     (ipc),
      .o_ifu_ins    (ins),
      .o_fq_count   (cnt)
    );

    // Reference model state
    fetch_entry_t sb [$];
    fetch_entry_t front;
    logic [31:0]  m_pc;
    bit           m_pend;
    bit           was_rst;
    bit           exp_valid;
    bit           m_csh;
    bit           was_empty;
    bit           exp_pv;

    always @(negedge clk) begin
      if (rst) begin
        sb.delete();
        m_pc    = 32'h8000_0000;
        m_pend  = 1'b0;
        was_rst = 1'b1;
      end else begin
        exp_valid = !flush && (m_pend || (!hold && sb.size() < DEPTH));
        m_csh     = exp_valid && cache_ready;

        check($sformatf("dut%0d fq_count", g), 64'(cnt), 64'(sb.size()));
        check($sformatf("dut%0d req_valid", g), 64'(cif.valid), 64'(exp_valid));
        if (exp_valid) begin
          check($sformatf("dut%0d addr", g), 64'(cif.addr), 64'(m_pc));
          check($sformatf("dut%0d size/reqtyp", g), 64'({cif.size, cif.reqtyp}),
                64'({2'b10, REQ_READ}));
        end

        if (was_rst && !m_csh) begin
          check($sformatf("dut%0d reset post_valid", g), 64'(pv), 64'(0));
          check($sformatf("dut%0d reset pc/ins", g), {ipc, ins}, 64'(0));
        end
        was_rst = 1'b0;

        if (flush) begin
          check($sformatf("dut%0d flush post_valid", g), 64'(pv), 64'(0));
          sb.delete();
          m_pc   = flush_pc & ~32'h3;
          m_pend = 1'b0;
        end else begin
          // Stimulus side: every accepted request becomes an expected entry.
          was_empty = (sb.size() == 0);
          if (m_csh) begin
            sb.push_back({m_pc, rdata});
            m_pc = m_pc + 32'd4;
          end
          m_pend = exp_valid && !cache_ready;

          // Monitor side: whatever decode takes must be the oldest entry.
          exp_pv = !was_empty || (BYP && m_csh);
          check($sformatf("dut%0d post_valid", g), 64'(pv), 64'(exp_pv));
          if (pv && post_ready && sb.size() > 0) begin
            front = sb.pop_front();
            check($sformatf("dut%0d pc/ins", g), {ipc, ins}, {front.pc, front.ins});
            delivered[g]++;
          end
        end
      end
    end
  end

  task automatic step(input bit r, input bit cr, input bit pr, input bit h,
                      input bit f, input logic [31:0] fpc);
    rst         = r;
    cache_ready = cr;
    post_ready  = pr;
    hold        = h;
    flush       = f;
    flush_pc    = fpc;
    rdata       = $urandom;
    @(posedge clk);
    #1;
  endtask

  initial begin
    delivered[0] = 0;
    delivered[1] = 0;
    rst = 1'b1; flush = 1'b0; flush_pc = '0; hold = 1'b0;
    post_ready = 1'b0; cache_ready = 1'b0; rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    // First cycle out of reset with the cache stalled: reset outputs visible.
    step(0, 0, 1, 0, 0, 0);
    // Streaming, one instruction per cycle.
    repeat (6) step(0, 1, 1, 0, 0, 0);
    // Decode stalled: queue fills and fetch stops.
    repeat (8) step(0, 1, 0, 0, 0, 0);
    repeat (8) step(0, 1, 1, 0, 0, 0);
    // Cache stall with hold pulsed while a request is pending.
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    // Partially fill, then redirect with a handshake in the same cycle.
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h8000_1002);
    repeat (4) step(0, 1, 1, 0, 0, 0);
    // Redirect near the top of the address space: PC wraps to zero.
    step(0, 1, 1, 0, 1, 32'hFFFF_FFF8);
    repeat (4) step(0, 1, 1, 0, 0, 0);
    // Randomised traffic with occasional redirects and resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 300) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
           ($urandom % 8) == 0, ($urandom % 40) == 0, $urandom);
    end
    repeat (20) step(0, 1, 1, 0, 0, 0);

    check("dut0 progress", 64'(delivered[0] > 200), 64'(1));
    check("dut1 progress", 64'(delivered[1] > 200), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
